nbit_logic_checker: RTL and testbench
=====================================

NBIT_LOGIC_CHECKER -- requirements
Module: nbit_logic_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4: operand width of the gate set under check.
REQ-002 The module SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have input start, 1 bit: arm and clear the checker for a new sweep.
REQ-005 The module SHALL have input valid, 1 bit: current vector and responses are sampled this cycle.
REQ-006 The module SHALL have inputs in1 and in2, WIDTH bits each: operands that were applied to the gates.
REQ-007 The module SHALL have inputs not_out, and_out, or_out, nand_out, nor_out, xor_out and xnor_out, WIDTH bits each: gate responses, with not_out responding to in1.
REQ-008 The module SHALL have output busy, 1 bit: high in state CHECK.
REQ-009 The module SHALL have output done, 1 bit: high in state DONE.
REQ-010 The module SHALL have output pass, 1 bit: high in state DONE only when error_count==0.
REQ-011 The module SHALL have output error_count, 16 bits: count of failing vectors; saturates at 0xFFFF.
REQ-012 The module SHALL have output vector_count, 2*WIDTH+1 bits: count of vectors accepted.
REQ-013 The module SHALL have output first_fail_vec, 2*WIDTH bits: {in1,in2} of the first failing vector.
REQ-014 The module SHALL have output first_fail_mask, 8 bits: failure flags of the first failing vector, with bit0 NOT, bit1 AND, bit2 OR, bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR, bit7 sequence.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK and DONE.
REQ-016 The FSM SHALL move from IDLE to CHECK on start, and SHALL clear error_count, vector_count, first_fail_vec and first_fail_mask in the same cycle.
REQ-017 The FSM SHALL, on start while in CHECK or DONE, clear the same registers and enter CHECK (restart).
REQ-018 When start and valid are both high in one cycle, start SHALL win and the vector SHALL be ignored.
REQ-019 In CHECK with valid high, the checker SHALL compute per-gate expected values bitwise: ~in1, in1&in2, in1|in2, ~(in1&in2), ~(in1|in2), in1^in2, ~(in1^in2).
REQ-020 The checker SHALL set bit7 (sequence error) when {in1,in2} != vector_count[2*WIDTH-1:0], so vectors are required in ascending order from 0.
REQ-021 A vector SHALL fail when any of the 8 flags is set; on failure error_count SHALL increment, holding at 0xFFFF once saturated.
REQ-022 On the first failure of a sweep, the checker SHALL latch first_fail_vec and first_fail_mask; later failures SHALL leave them unchanged.
REQ-023 vector_count SHALL increment on every accepted vector.
REQ-024 Latency SHALL be 1 cycle: all outputs reflect a vector on the clock edge after its valid cycle.
REQ-025 When the accepted vector brings vector_count to 2^(2*WIDTH), the FSM SHALL enter DONE on that edge.
REQ-026 In IDLE and DONE, valid SHALL be ignored, and DONE SHALL hold all result outputs stable.
REQ-027 Gaps in valid SHALL cause no state change.

Reset
REQ-028 When rst is high at a clock edge, the module SHALL enter IDLE and drive busy, done, pass, error_count, vector_count, first_fail_vec and first_fail_mask to 0 on that edge.
REQ-029 rst SHALL override start and valid.
REQ-030 rst asserted mid-sweep SHALL abort the sweep, and a new start SHALL be required.

Verification (WIDTH=4, 256 vectors)
REQ-031 The bench SHALL cover this clean sweep: rst, start, then 256 ordered correct vectors on consecutive cycles -> one cycle after the last vector, done=1, pass=1, error_count=0, vector_count=256, first_fail_mask=0x00.
REQ-032 The bench SHALL cover this single gate fault: xor_out inverted only at in1=3, in2=5 -> error_count=1, first_fail_vec=0x35, first_fail_mask=0x20, pass=0.
REQ-033 The bench SHALL cover this order fault: vector 0x10 skipped (0x11 sent at index 16) with correct responses -> first_fail_vec=0x11, first_fail_mask=0x80, and every following vector also counts as an error.
REQ-034 The bench SHALL cover this valid gaps case: the clean sweep with random 0-3 cycle valid gaps -> results identical to REQ-031.
REQ-035 The bench SHALL cover this mid-sweep reset: rst pulsed after 100 vectors -> all outputs 0 next cycle, and later valid pulses without start leave vector_count=0.
REQ-036 The bench SHALL cover this restart: start re-asserted after 50 vectors carrying one fault -> counters cleared, and a following clean sweep gives pass=1.

Source files
------------

// File: rtl/nbit_logic_checker.sv
// Purpose: checks the responses of a WIDTH-bit NOT/AND/OR/NAND/NOR/XOR/XNOR gate set
//          against an exhaustive ascending operand sweep, counting and locating failures.
// Latency: 1 cycle from a valid vector to updated counters and results.
// Backpressure: none; one vector per valid cycle is always accepted while busy,
//               and valid is ignored in IDLE and DONE.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    arm/clear for a new sweep (also restarts a sweep in progress)
//   valid, in1, in2          vector strobe and the operands applied to the gates
//   not_out .. xnor_out      gate responses under check (not_out responds to in1)
//   busy, done, pass         sweep status: checking, finished, finished with no failures
//   error_count              failing vectors, saturating at 0xFFFF
//   vector_count             vectors accepted this sweep
//   first_fail_vec/_mask     {in1,in2} and flag set of the first failing vector
//                            (mask bit0 NOT .. bit6 XNOR, bit7 out-of-order vector)
module nbit_logic_checker #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [WIDTH-1:0]     not_out,
  input  logic [WIDTH-1:0]     and_out,
  input  logic [WIDTH-1:0]     or_out,
  input  logic [WIDTH-1:0]     nand_out,
  input  logic [WIDTH-1:0]     nor_out,
  input  logic [WIDTH-1:0]     xor_out,
  input  logic [WIDTH-1:0]     xnor_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          error_count,
  output logic [2*WIDTH:0]     vector_count,
  output logic [2*WIDTH-1:0]   first_fail_vec,
  output logic [7:0]           first_fail_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  // vector_count value just before the final vector of a full sweep is accepted
  localparam logic [2*WIDTH:0] LAST_IDX = {1'b0, {(2*WIDTH){1'b1}}};

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [15:0]          err_q;
  logic [2*WIDTH:0]     vcnt_q;
  logic [2*WIDTH-1:0]   ffv_q;
  logic [7:0]           ffm_q;

  logic [7:0]           mask_d;
  logic                 fail_d;
  logic [15:0]          err_d;

  // Per-gate mismatch flags plus the ordering check for the current vector
  always_comb begin
    mask_d    = 8'h00;
    mask_d[0] = |(not_out  ^ ~in1);
    mask_d[1] = |(and_out  ^ (in1 & in2));
    mask_d[2] = |(or_out   ^ (in1 | in2));
    mask_d[3] = |(nand_out ^ ~(in1 & in2));
    mask_d[4] = |(nor_out  ^ ~(in1 | in2));
    mask_d[5] = |(xor_out  ^ (in1 ^ in2));
    mask_d[6] = |(xnor_out ^ ~(in1 ^ in2));
    mask_d[7] = ({in1, in2} != vcnt_q[2*WIDTH-1:0]);
    fail_d    = |mask_d;
    err_d     = err_q;
    if (fail_d && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      vcnt_q  <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
    end else if (start) begin
      // start from any state clears the results and (re)arms; a coincident vector is dropped
      state_q <= CHECK;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      vcnt_q  <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
    end else begin
      case (state_q)
        CHECK: begin
          if (valid) begin
            vcnt_q <= vcnt_q + 1'b1;
            err_q  <= err_d;
            // err_q still zero means no earlier failure in this sweep
            if (fail_d && (err_q == 16'd0)) begin
              ffv_q <= {in1, in2};
              ffm_q <= mask_d;
            end
            if (vcnt_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 16'd0);
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign vector_count    = vcnt_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_nbit_logic_checker.sv
// Directed bench for nbit_logic_checker at WIDTH=4 (256-vector sweeps).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_nbit_logic_checker;

  logic       clk = 1'b0;
  logic       rst, start, valid;
  logic [3:0] in1, in2;
  logic [3:0] not_out, and_out, or_out, nand_out, nor_out, xor_out, xnor_out;
  logic       busy, done, pass;
  logic [15:0] error_count;
  logic [8:0]  vector_count;
  logic [7:0]  first_fail_vec;
  logic [7:0]  first_fail_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nbit_logic_checker #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .in1(in1), .in2(in2),
    .not_out(not_out), .and_out(and_out), .or_out(or_out),
    .nand_out(nand_out), .nor_out(nor_out), .xor_out(xor_out), .xnor_out(xnor_out),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .vector_count(vector_count),
    .first_fail_vec(first_fail_vec), .first_fail_mask(first_fail_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one vector with correct gate responses, each gate optionally inverted (inv bit k = gate k).
  task automatic drive_vec(input logic [7:0] v, input logic [6:0] inv);
    logic [3:0] a, b;
    a = v[7:4];
    b = v[3:0];
    in1      = a;
    in2      = b;
    not_out  = ~a        ^ {4{inv[0]}};
    and_out  = (a & b)   ^ {4{inv[1]}};
    or_out   = (a | b)   ^ {4{inv[2]}};
    nand_out = ~(a & b)  ^ {4{inv[3]}};
    nor_out  = ~(a | b)  ^ {4{inv[4]}};
    xor_out  = (a ^ b)   ^ {4{inv[5]}};
    xnor_out = ~(a ^ b)  ^ {4{inv[6]}};
    valid    = 1'b1;
    tick();
    valid    = 1'b0;
  endtask

  // n vectors from index 0; skip16 sends idx+1 from index 16 on; one optional faulty index.
  task automatic sweep(input int n, input bit skip16, input int fault_idx,
                       input logic [6:0] inv, input bit gaps);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = (skip16 && i >= 16) ? 8'(i + 1) : 8'(i);
      drive_vec(v, (i == fault_idx) ? inv : 7'h00);
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) tick();
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_clean(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"},  32'(error_count), 32'd0);
    chk({tag, "_vcnt"}, 32'(vector_count), 32'd256);
    chk({tag, "_mask"}, 32'(first_fail_mask), 32'h00);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"},  32'(error_count), 32'd0);
    chk({tag, "_vcnt"}, 32'(vector_count), 32'd0);
    chk({tag, "_ffv"},  32'(first_fail_vec), 32'd0);
    chk({tag, "_mask"}, 32'(first_fail_mask), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    in1 = '0; in2 = '0;
    not_out = '0; and_out = '0; or_out = '0; nand_out = '0;
    nor_out = '0; xor_out = '0; xnor_out = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    // Valid in IDLE is ignored
    drive_vec(8'h00, 7'h00);
    chk("idle_valid_vcnt", 32'(vector_count), 32'd0);

    // Clean sweep
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_vcnt", 32'(vector_count), 32'd0);
    sweep(256, 1'b0, -1, 7'h00, 1'b0);
    chk_clean("clean");
    // DONE holds results while valid keeps arriving
    drive_vec(8'h00, 7'h7F);
    drive_vec(8'h01, 7'h00);
    chk("done_hold_vcnt", 32'(vector_count), 32'd256);
    chk("done_hold_err",  32'(error_count), 32'd0);
    chk("done_hold_done", 32'(done), 32'd1);

    // Single XOR fault at in1=3, in2=5
    do_start();
    sweep(256, 1'b0, 8'h35, 7'b0100000, 1'b0);
    chk("xor_done", 32'(done), 32'd1);
    chk("xor_pass", 32'(pass), 32'd0);
    chk("xor_err",  32'(error_count), 32'd1);
    chk("xor_ffv",  32'(first_fail_vec), 32'h35);
    chk("xor_mask", 32'(first_fail_mask), 32'h20);

    // Order fault: 0x10 skipped, every vector from index 16 on is out of sequence
    do_start();
    sweep(17, 1'b1, -1, 7'h00, 1'b0);
    chk("order_err17",  32'(error_count), 32'd1);
    chk("order_ffv",    32'(first_fail_vec), 32'h11);
    chk("order_mask",   32'(first_fail_mask), 32'h80);
    // continue from index 17 (vector 0x12) to the end of the sweep
    for (int i = 17; i < 256; i++) drive_vec(8'(i + 1), 7'h00);
    chk("order_done",   32'(done), 32'd1);
    chk("order_pass",   32'(pass), 32'd0);
    chk("order_err",    32'(error_count), 32'd240);
    chk("order_ffv_end", 32'(first_fail_vec), 32'h11);
    chk("order_mask_end", 32'(first_fail_mask), 32'h80);

    // Clean sweep with random valid gaps
    do_start();
    sweep(256, 1'b0, -1, 7'h00, 1'b1);
    chk_clean("gaps");

    // Mid-sweep reset
    do_start();
    sweep(100, 1'b0, 40, 7'b0000001, 1'b0);
    chk("mid_vcnt", 32'(vector_count), 32'd100);
    chk("mid_err",  32'(error_count), 32'd1);
    chk("mid_mask", 32'(first_fail_mask), 32'h01);
    do_reset();
    chk_zero("midrst");
    drive_vec(8'h00, 7'h00);
    drive_vec(8'h01, 7'h00);
    chk("midrst_vcnt", 32'(vector_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Restart after 50 vectors carrying an AND fault; start coincides with a valid vector
    do_start();
    sweep(50, 1'b0, 10, 7'b0000010, 1'b0);
    chk("rs_err",  32'(error_count), 32'd1);
    chk("rs_ffv",  32'(first_fail_vec), 32'h0A);
    chk("rs_mask", 32'(first_fail_mask), 32'h02);
    start = 1'b1;
    drive_vec(8'h00, 7'h00);
    start = 1'b0;
    chk_zero_busy();
    sweep(256, 1'b0, -1, 7'h00, 1'b0);
    chk_clean("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic chk_zero_busy();
    chk("rs_clr_busy", 32'(busy), 32'd1);
    chk("rs_clr_err",  32'(error_count), 32'd0);
    chk("rs_clr_vcnt", 32'(vector_count), 32'd0);
    chk("rs_clr_ffv",  32'(first_fail_vec), 32'd0);
    chk("rs_clr_mask", 32'(first_fail_mask), 32'd0);
  endtask

endmodule
